hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 16-bit pipelined processor. It produces the stall and flush controls for the IF, IF/ID, ID/EX and EX/MEM registers, and it resolves the following:
- load-use hazards;
- multi-cycle floating-point occupancy of EX;
- taken branches and jumps;
- the STOP-instruction drain and halt sequence.

It sits beside the ID stage. It reads decoded register fields from ID and control bits from the ID/EX register.

---
 rtl/hazard_ctrl_pkg.sv | 25 ++
 rtl/hazard_ctrl_fp_occupancy.sv | 41 ++++
 rtl/hazard_ctrl.sv | 161 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_pkg
// Shared definitions for the pipeline hazard/sequencing controller:
//   - sequencer state encoding (RUN, DRAIN, HALTED)
//   - default floating-point EX occupancy and post-STOP drain length
//   - helper that sizes the FP occupancy counter
// -----------------------------------------------------------------------------
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } hz_state_t;

    localparam int unsigned FP_LATENCY_DEF   = 3;
    localparam int unsigned DRAIN_CYCLES_DEF = 3;

    // One bit of headroom above ceil(log2(latency)) so the counter can
    // always represent latency-1, including the degenerate latency of 1.
    function automatic int unsigned fp_cnt_width(input int unsigned lat);
        return $clog2(lat) + 1;
    endfunction

endpackage

// File: rtl/hazard_ctrl_fp_occupancy.sv
// -----------------------------------------------------------------------------
// fp_occupancy
// Tracks how long a Floating op has been sitting in EX and reports whether it
// still needs to hold the stage.
// Ports:
//   clk          in   clock
//   rst          in   synchronous active-high reset
//   i_floating   in   a Floating op is in ID/EX
//   o_fp_busy    out  the op needs EX for at least one more cycle
// -----------------------------------------------------------------------------
module fp_occupancy
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned FP_LATENCY = FP_LATENCY_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_floating,
    output logic o_fp_busy
);

    localparam int unsigned   CW      = fp_cnt_width(FP_LATENCY);
    localparam logic [CW-1:0] CNT_END = CW'(FP_LATENCY - 1);

    logic [CW-1:0] r_fp_cnt;

    // The last occupancy cycle is not busy: the op completes and the next
    // instruction may enter EX on the following edge.
    assign o_fp_busy = i_floating && (r_fp_cnt != CNT_END);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fp_cnt <= '0;
        end else if (o_fp_busy) begin
            r_fp_cnt <= r_fp_cnt + CW'(1);
        end else begin
            r_fp_cnt <= '0;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Stall/flush generator for the IF, IF/ID, ID/EX and EX/MEM registers plus the
// STOP drain-and-halt sequencer.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   RUN     | normal issue; hazards resolved by priority
//   DRAIN   | STOP has left ID; fetch frozen while EX/MEM/WB empty out
//   HALTED  | processor stopped; everything stalled until reset
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   rsD, rtD                        source registers of the ID instruction
//   rtE, rdE, RegDstE               destination candidates/select in ID/EX
//   RegWriteE, MemReadE, FloatingE  ID/EX control bits
//   branch_taken_E                  branch in EX resolved taken
//   JumpD, StopD                    decoded in ID
//   stall_*_o, flush_*_o            pipeline register controls
//   fp_busy_o                       a Floating op is holding EX
//   halted_o                        processor has stopped
// -----------------------------------------------------------------------------
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_WIDTH    = 4,
    parameter int unsigned FP_LATENCY   = FP_LATENCY_DEF,
    parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_WIDTH-1:0] rsD,
    input  logic [REG_WIDTH-1:0] rtD,
    input  logic [REG_WIDTH-1:0] rtE,
    input  logic [REG_WIDTH-1:0] rdE,
    input  logic                 RegDstE,
    input  logic                 RegWriteE,
    input  logic                 MemReadE,
    input  logic                 FloatingE,
    input  logic                 branch_taken_E,
    input  logic                 JumpD,
    input  logic                 StopD,
    output logic                 stall_IF_o,
    output logic                 stall_IF_ID_o,
    output logic                 flush_IF_ID_o,
    output logic                 stall_ID_EX_o,
    output logic                 flush_ID_EX_o,
    output logic                 flush_EX_MEM_o,
    output logic                 fp_busy_o,
    output logic                 halted_o
);

    localparam int unsigned DCW = $clog2(DRAIN_CYCLES) + 1;

    hz_state_t          r_state;
    hz_state_t          w_state_nxt;
    logic [DCW-1:0]     r_drain_cnt;
    logic [DCW-1:0]     w_drain_nxt;
    logic [REG_WIDTH-1:0] w_dst_e;
    logic               w_lu;
    logic               w_fp_busy;
    logic               w_id_adv;

    fp_occupancy #(
        .FP_LATENCY (FP_LATENCY)
    ) u_fp_occupancy (
        .clk        (clk),
        .rst        (rst),
        .i_floating (FloatingE),
        .o_fp_busy  (w_fp_busy)
    );

    assign w_dst_e  = RegDstE ? rdE : rtE;
    assign w_lu     = MemReadE && RegWriteE && ((w_dst_e == rsD) || (w_dst_e == rtD));
    assign w_id_adv = !branch_taken_E && !w_fp_busy && !w_lu;

    always_comb begin
        w_state_nxt    = r_state;
        w_drain_nxt    = r_drain_cnt;
        stall_IF_o     = 1'b0;
        stall_IF_ID_o  = 1'b0;
        flush_IF_ID_o  = 1'b0;
        stall_ID_EX_o  = 1'b0;
        flush_ID_EX_o  = 1'b0;
        flush_EX_MEM_o = 1'b0;
        fp_busy_o      = 1'b0;
        halted_o       = 1'b0;

        case (r_state)
            ST_RUN: begin
                fp_busy_o = w_fp_busy;
                if (branch_taken_E) begin
                    flush_IF_ID_o = 1'b1;
                    flush_ID_EX_o = 1'b1;
                end else if (w_fp_busy) begin
                    stall_IF_o     = 1'b1;
                    stall_IF_ID_o  = 1'b1;
                    stall_ID_EX_o  = 1'b1;
                    flush_EX_MEM_o = 1'b1;
                end else if (w_lu) begin
                    stall_IF_o    = 1'b1;
                    stall_IF_ID_o = 1'b1;
                    flush_ID_EX_o = 1'b1;
                end else if (JumpD) begin
                    flush_IF_ID_o = 1'b1;
                end
                // A STOP that is stalled or squashed by a branch stays put.
                if (StopD && w_id_adv) begin
                    w_state_nxt = ST_DRAIN;
                    w_drain_nxt = DCW'(DRAIN_CYCLES - 1);
                end
            end
            ST_DRAIN: begin
                // IF/ID only ever carries bubbles now, so ID/EX just loads them
                // unless an FP op still owns EX.
                stall_IF_o    = 1'b1;
                flush_IF_ID_o = 1'b1;
                if (w_fp_busy) begin
                    fp_busy_o      = 1'b1;
                    stall_ID_EX_o  = 1'b1;
                    flush_EX_MEM_o = 1'b1;
                end else if (r_drain_cnt == '0) begin
                    w_state_nxt = ST_HALTED;
                end else begin
                    w_drain_nxt = r_drain_cnt - DCW'(1);
                end
            end
            ST_HALTED: begin
                halted_o      = 1'b1;
                stall_IF_o    = 1'b1;
                stall_IF_ID_o = 1'b1;
                stall_ID_EX_o = 1'b1;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase

        if (rst) begin
            stall_IF_o     = 1'b0;
            stall_IF_ID_o  = 1'b0;
            flush_IF_ID_o  = 1'b0;
            stall_ID_EX_o  = 1'b0;
            flush_ID_EX_o  = 1'b0;
            flush_EX_MEM_o = 1'b0;
            fp_busy_o      = 1'b0;
            halted_o       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_nxt;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Two controllers share one stimulus stream: one with FP latency 3, one with
// FP latency 1. A behavioural model predicts every output each cycle; a few
// hand-computed sequences pin the model to known-good values.
// Output vector bit order:
//   [7] stall_IF [6] stall_IF_ID [5] flush_IF_ID [4] stall_ID_EX
//   [3] flush_ID_EX [2] flush_EX_MEM [1] fp_busy [0] halted
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int DRAIN = 3;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] rsD, rtD, rtE, rdE;
    logic       RegDstE, RegWriteE, MemReadE, FloatingE;
    logic       branch_taken_E, JumpD, StopD;
    logic [7:0] out_a, out_b;

    int errors = 0;
    int checks = 0;

    hazard_ctrl #(.REG_WIDTH(4), .FP_LATENCY(3), .DRAIN_CYCLES(DRAIN)) u_dut_a (
        .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .rtE(rtE), .rdE(rdE),
        .RegDstE(RegDstE), .RegWriteE(RegWriteE), .MemReadE(MemReadE),
        .FloatingE(FloatingE), .branch_taken_E(branch_taken_E),
        .JumpD(JumpD), .StopD(StopD),
        .stall_IF_o(out_a[7]), .stall_IF_ID_o(out_a[6]), .flush_IF_ID_o(out_a[5]),
        .stall_ID_EX_o(out_a[4]), .flush_ID_EX_o(out_a[3]), .flush_EX_MEM_o(out_a[2]),
        .fp_busy_o(out_a[1]), .halted_o(out_a[0])
    );

    hazard_ctrl #(.REG_WIDTH(4), .FP_LATENCY(1), .DRAIN_CYCLES(DRAIN)) u_dut_b (
        .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .rtE(rtE), .rdE(rdE),
        .RegDstE(RegDstE), .RegWriteE(RegWriteE), .MemReadE(MemReadE),
        .FloatingE(FloatingE), .branch_taken_E(branch_taken_E),
        .JumpD(JumpD), .StopD(StopD),
        .stall_IF_o(out_b[7]), .stall_IF_ID_o(out_b[6]), .flush_IF_ID_o(out_b[5]),
        .stall_ID_EX_o(out_b[4]), .flush_ID_EX_o(out_b[3]), .flush_EX_MEM_o(out_b[2]),
        .fp_busy_o(out_b[1]), .halted_o(out_b[0])
    );

    // ---------------- behavioural model ----------------
    // phase: 0 running, 1 draining, 2 halted
    int lat[2]        = '{3, 1};
    int phase[2]      = '{0, 0};
    int fp_age[2]     = '{0, 0};   // cycles the current FP op has already held EX
    int drain_left[2] = '{0, 0};   // clean cycles still needed before halt

    function automatic logic m_lu();
        logic [3:0] dst;
        dst = RegDstE ? rdE : rtE;
        return MemReadE && RegWriteE && (dst == rsD || dst == rtD);
    endfunction

    function automatic logic m_fpb(input int k);
        return FloatingE && (fp_age[k] + 1 < lat[k]);
    endfunction

    function automatic logic [7:0] model_out(input int k);
        logic [7:0] o;
        logic       fpb;
        o   = 8'h00;
        fpb = m_fpb(k);
        if (rst) return 8'h00;
        if (phase[k] == 0) begin
            o[1] = fpb;
            if (branch_taken_E)  begin o[5] = 1'b1; o[3] = 1'b1; end
            else if (fpb)        begin o[7] = 1'b1; o[6] = 1'b1; o[4] = 1'b1; o[2] = 1'b1; end
            else if (m_lu())     begin o[7] = 1'b1; o[6] = 1'b1; o[3] = 1'b1; end
            else if (JumpD)      o[5] = 1'b1;
        end else if (phase[k] == 1) begin
            o[7] = 1'b1;
            o[5] = 1'b1;
            if (fpb) begin o[4] = 1'b1; o[2] = 1'b1; o[1] = 1'b1; end
        end else begin
            o = 8'b1101_0001;
        end
        return o;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic fpb;
            fpb = m_fpb(k);
            if (rst) begin
                phase[k]      = 0;
                fp_age[k]     = 0;
                drain_left[k] = 0;
            end else begin
                if (phase[k] == 0) begin
                    if (StopD && !branch_taken_E && !fpb && !m_lu()) begin
                        phase[k]      = 1;
                        drain_left[k] = DRAIN;
                    end
                end else if (phase[k] == 1) begin
                    if (!fpb) begin
                        drain_left[k] = drain_left[k] - 1;
                        if (drain_left[k] == 0) phase[k] = 2;
                    end
                end
                fp_age[k] = fpb ? fp_age[k] + 1 : 0;
            end
        end
    end

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    // Continuous comparison of both instances against the model.
    always @(negedge clk) begin
        check("model_a", out_a, model_out(0));
        check("model_b", out_b, model_out(1));
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        rsD = 4'd0; rtD = 4'd0; rtE = 4'd0; rdE = 4'd0;
        RegDstE = 1'b0; RegWriteE = 1'b0; MemReadE = 1'b0; FloatingE = 1'b0;
        branch_taken_E = 1'b0; JumpD = 1'b0; StopD = 1'b0;
    endtask

    // Hold the current inputs for one cycle and check instance A literally.
    task automatic cyc(input logic [7:0] exp, input string name);
        @(negedge clk);
        #1;
        check(name, out_a, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        cyc(8'h00, "reset0");
        cyc(8'h00, "reset1");
        rst = 1'b0;

        // load-use via rs, rt, rd; and a non-matching register
        MemReadE = 1; RegWriteE = 1; rtE = 4'd5; rsD = 4'd5;
        cyc(8'b1100_1000, "lu_rs");
        idle(); cyc(8'h00, "lu_rs_clear");
        MemReadE = 1; RegWriteE = 1; rtE = 4'd5; rtD = 4'd5;
        cyc(8'b1100_1000, "lu_rt");
        idle(); cyc(8'h00, "lu_rt_clear");
        MemReadE = 1; RegWriteE = 1; rtE = 4'd5; rsD = 4'd6;
        cyc(8'h00, "lu_nomatch");
        idle(); MemReadE = 1; RegWriteE = 1; RegDstE = 1; rdE = 4'd7; rtE = 4'd5; rsD = 4'd7;
        cyc(8'b1100_1000, "lu_rd");
        idle();

        // FP op held for three cycles: two busy, one completing
        FloatingE = 1;
        cyc(8'b1101_0110, "fp_busy1");
        cyc(8'b1101_0110, "fp_busy2");
        cyc(8'h00, "fp_last");
        idle(); cyc(8'h00, "fp_done");

        // branch beats load-use
        branch_taken_E = 1; MemReadE = 1; RegWriteE = 1; rtE = 4'd5; rsD = 4'd5;
        cyc(8'b0010_1000, "br_over_lu");
        idle();

        JumpD = 1;
        cyc(8'b0010_0000, "jump");
        idle();

        // STOP held by load-use, then squashed by a branch
        StopD = 1; MemReadE = 1; RegWriteE = 1; rtE = 4'd3; rtD = 4'd3;
        cyc(8'b1100_1000, "stop_lu");
        idle(); StopD = 1; branch_taken_E = 1;
        cyc(8'b0010_1000, "stop_br");
        idle();
        cyc(8'h00, "stop_squashed");
        cyc(8'h00, "still_run");

        // STOP drains and halts; reset recovers
        StopD = 1;
        cyc(8'h00, "stop_adv");
        idle();
        cyc(8'b1010_0000, "drain1");
        cyc(8'b1010_0000, "drain2");
        cyc(8'b1010_0000, "drain3");
        cyc(8'b1101_0001, "halt1");
        cyc(8'b1101_0001, "halt2");
        rst = 1;
        cyc(8'h00, "halt_rst");
        rst = 0;
        cyc(8'h00, "after_rst");

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rst            = ($urandom_range(0, 59) == 0);
            rsD            = 4'(4 + $urandom_range(0, 3));
            rtD            = 4'(4 + $urandom_range(0, 3));
            rtE            = 4'(4 + $urandom_range(0, 3));
            rdE            = 4'(4 + $urandom_range(0, 3));
            RegDstE        = 1'($urandom_range(0, 1));
            RegWriteE      = 1'($urandom_range(0, 1));
            MemReadE       = ($urandom_range(0, 2) == 0);
            FloatingE      = ($urandom_range(0, 3) == 0);
            branch_taken_E = ($urandom_range(0, 9) == 0);
            JumpD          = ($urandom_range(0, 7) == 0);
            StopD          = ($urandom_range(0, 5) == 0);
            @(posedge clk);
            #1;
        end

        rst = 0;
        idle();
        @(negedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
